// File: rtl/sync_debouncer.sv
// Per-channel level debouncer with edge pulses, sticky events and an irq.
// Each channel needs STABLE_CYCLES equal samples before its level changes.
module sync_debouncer #(
  parameter int DATA_WIDTH    = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] d_sync_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] clr_i,
  output logic [DATA_WIDTH-1:0] d_stable_o,
  output logic [DATA_WIDTH-1:0] rise_o,
  output logic [DATA_WIDTH-1:0] fall_o,
  output logic [DATA_WIDTH-1:0] event_o,
  output logic                  irq_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHECK_HIGH,
    STABLE_HIGH,
    CHECK_LOW
  } state_e;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_ch
    state_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stb_q, stb_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          evt_q, evt_d;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        st_q   <= STABLE_LOW;
        cnt_q  <= '0;
        stb_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        evt_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        stb_q  <= stb_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        evt_q  <= evt_d;
      end
    end

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      stb_d  = stb_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      // Set beats clear: the registered pulse lands one edge later.
      evt_d  = (evt_q & ~clr_i[i]) | rise_q | fall_q;
      if (!enable_i) begin
        cnt_d = '0;
        if (st_q == CHECK_HIGH) st_d = STABLE_LOW;
        if (st_q == CHECK_LOW)  st_d = STABLE_HIGH;
      end else begin
        unique case (st_q)
          STABLE_LOW: begin
            cnt_d = d_sync_i[i] ? CW'(1) : '0;
            if (d_sync_i[i]) st_d = CHECK_HIGH;
          end
          CHECK_HIGH: begin
            if (!d_sync_i[i]) begin
              st_d  = STABLE_LOW;
              cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
              st_d   = STABLE_HIGH;
              cnt_d  = '0;
              stb_d  = 1'b1;
              rise_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          STABLE_HIGH: begin
            cnt_d = !d_sync_i[i] ? CW'(1) : '0;
            if (!d_sync_i[i]) st_d = CHECK_LOW;
          end
          CHECK_LOW: begin
            if (d_sync_i[i]) begin
              st_d  = STABLE_HIGH;
              cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
              st_d   = STABLE_LOW;
              cnt_d  = '0;
              stb_d  = 1'b0;
              fall_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            st_d  = STABLE_LOW;
            cnt_d = '0;
          end
        endcase
      end
    end

    assign d_stable_o[i] = stb_q;
    assign rise_o[i]     = rise_q;
    assign fall_o[i]     = fall_q;
    assign event_o[i]    = evt_q;
  end

  assign irq_o = |event_o;

endmodule
